// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: FSM states, requester ids,
// and the width of the read-latency down-counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_t;

  typedef enum logic {
    RID_CPU = 1'b0,
    RID_DBG = 1'b1
  } rid_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin picker.
// Ports: i_req[0]=CPU, i_req[1]=DBG, i_last_grant, o_gnt one-hot.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    unique case (1'b1)
      (i_req[0] & ~i_req[1]): o_gnt = 2'b01;
      (i_req[1] & ~i_req[0]): o_gnt = 2'b10;
      (i_req[0] &  i_req[1]):
        o_gnt = (i_last_grant == RID_DBG) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between CPU and debug.
// Ports: clk, reset (async, active-low); cpu_*/dbg_* requesters
// (req/we/addr/wdata in, ack/rdata out); mem_* memory port; err.
// Build option DMEM_ARB_ALIGN_CHECK_EN: misaligned accesses are
// acked at once with err=1 and never reach memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DBITS       = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DBITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic [DBITS-1:0] cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [DBITS-1:0] dbg_addr,
  input  logic [DBITS-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [DBITS-1:0] dbg_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [DBITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wdata,
  input  logic [DBITS-1:0] mem_rdata,
  output logic             err
);

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_last, w_last;
  logic               r_owner, w_owner;
  logic               r_we, w_we;
  logic               r_mem_en, w_mem_en;
  logic               r_mem_we, w_mem_we;
  logic [DBITS-1:0]   r_mem_addr, w_mem_addr;
  logic [DBITS-1:0]   r_mem_wdata, w_mem_wdata;
  logic               r_cpu_ack, w_cpu_ack;
  logic               r_dbg_ack, w_dbg_ack;
  logic [DBITS-1:0]   r_rdata, w_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic               r_err, w_err;
`endif

  logic [1:0]         w_gnt;
  logic               w_sel_dbg;
  logic               w_sel_we;
  logic [DBITS-1:0]   w_sel_addr;
  logic [DBITS-1:0]   w_sel_wdata;

  rr_arbiter2 u_rr (
    .i_req        ({dbg_req, cpu_req}),
    .i_last_grant (r_last),
    .o_gnt        (w_gnt)
  );

  assign w_sel_dbg   = w_gnt[1];
  assign w_sel_we    = w_sel_dbg ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_sel_dbg ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_sel_dbg ? dbg_wdata : cpu_wdata;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_last      = r_last;
    w_owner     = r_owner;
    w_we        = r_we;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_cpu_ack   = 1'b0;
    w_dbg_ack   = 1'b0;
    w_rdata     = r_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    w_err       = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (|w_gnt) begin
          w_owner     = w_sel_dbg;
          w_last      = w_sel_dbg;
          w_we        = w_sel_we;
          w_mem_addr  = w_sel_addr;
          w_mem_wdata = w_sel_wdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
          if (w_sel_addr[1:0] != 2'b00) begin
            w_state   = S_ACK;
            w_cpu_ack = ~w_sel_dbg;
            w_dbg_ack = w_sel_dbg;
            w_err     = 1'b1;
          end else
`endif
          begin
            w_state  = S_ACCESS;
            w_mem_en = 1'b1;
            w_mem_we = w_sel_we;
          end
        end
      end
      S_ACCESS: begin
        if (r_we || (MEM_LATENCY == 1)) begin
          w_state   = S_ACK;
          w_cpu_ack = ~r_owner;
          w_dbg_ack = r_owner;
          if (!r_we) w_rdata = mem_rdata;
        end else begin
          // WAIT covers MEM_LATENCY-1 cycles; 0 marks the last one
          w_state = S_WAIT;
          w_cnt   = CNT_W'(MEM_LATENCY - 2);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state   = S_ACK;
          w_cpu_ack = ~r_owner;
          w_dbg_ack = r_owner;
          w_rdata   = mem_rdata;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_ACK: begin
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last      <= RID_DBG;
      r_owner     <= RID_CPU;
      r_we        <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_last      <= w_last;
      r_owner     <= w_owner;
      r_we        <= w_we;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_cpu_ack   <= w_cpu_ack;
      r_dbg_ack   <= w_dbg_ack;
      r_rdata     <= w_rdata;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_err;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_rdata = r_rdata;
  assign dbg_rdata = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter
// with MEM_LATENCY=3 and a small behavioural memory.
module tb_dmem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;

  dmem_arbiter #(.DBITS(32), .MEM_LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] i);
    return (i == 8'h40) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, i};
  endfunction

  logic        mem_ready = 1'b0;
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[9:2]];

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          ack_cyc;
    int          men_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_dbg_ack"}, 32'(dbg_ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  // off = 1 when the request waits out an IDLE cycle first
  task automatic push(input logic dbg, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int off);
    exp_t e;
    e.dbg   = dbg;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    e.err   = (addr[1:0] != 2'b00);
`endif
    if (e.err) begin
      e.ack_cyc = off + 1;
      e.men_cyc = 0;
    end else begin
      e.men_cyc = off + 1;
      e.ack_cyc = off + (we ? 2 : LAT + 1);
      if (we) ref_mem[addr[9:2]] = wdata;
      else    ref_rdata = ref_mem[addr[9:2]];
    end
    e.rdata = ref_rdata;
    sb.push_back(e);
  endtask

  task automatic run_one();
    exp_t e;
    int   men_n;
    int   men_at;
    bit   done;
    e      = sb[0];
    men_n  = 0;
    men_at = 0;
    done   = 1'b0;
    for (int c = 1; c <= 24 && !done; c++) begin
      tick();
      if (mem_en) begin
        men_n++;
        men_at = c;
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (cpu_ack || dbg_ack) begin
        done = 1'b1;
        e = sb.pop_front();
        chk("ack_cycle", 32'(c), 32'(e.ack_cyc));
        chk("ack_who", {30'd0, cpu_ack, dbg_ack},
            e.dbg ? 32'd1 : 32'd2);
        chk("cpu_rdata", cpu_rdata, e.rdata);
        chk("dbg_rdata", dbg_rdata, e.rdata);
        chk("err", 32'(err), 32'(e.err));
        chk("mem_en_count", 32'(men_n), (e.men_cyc != 0) ? 32'd1 : 32'd0);
        chk("mem_en_cycle", 32'(men_at), 32'(e.men_cyc));
      end
    end
    n_tests++;
    assert (done) else begin
      n_fail++;
      $error("FAIL ack_timeout: got no ack expected ack");
      void'(sb.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    ref_rdata = '0;

    repeat (3) tick();
    chk_zero("rst");
    reset = 1'b1;
    tick();
    chk_zero("post_rst");

    // lone CPU read, latency 3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    push(1'b0, 1'b0, 32'h100, 32'h0, 0);
    run_one();
    cpu_req = 1'b0;
    tick();

    // reset pulse clears rdata and last_grant
    reset = 1'b0;
    ref_rdata = '0;
    #1;
    chk_zero("rst2");
    tick();
    reset = 1'b1;

    // simultaneous CPU write and DBG read after reset
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 32'h40; cpu_wdata = 32'h12;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
    push(1'b0, 1'b1, 32'h40, 32'h12, 0);
    push(1'b1, 1'b0, 32'h44, 32'h0, 1);
    run_one();
    cpu_req = 1'b0;
    run_one();
    dbg_req = 1'b0;
    tick();

    // debug reads back the CPU store
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    push(1'b1, 1'b0, 32'h40, 32'h0, 0);
    run_one();
    dbg_req = 1'b0;
    tick();

    // both held high: grants alternate
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h48; dbg_wdata = 32'hA5;
    push(1'b0, 1'b0, 32'h100, 32'h0, 0);
    push(1'b1, 1'b1, 32'h48, 32'hA5, 1);
    push(1'b0, 1'b0, 32'h100, 32'h0, 1);
    push(1'b1, 1'b1, 32'h48, 32'hA5, 1);
    for (int k = 0; k < 4; k++) run_one();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();

    // reset during WAIT aborts with no ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
    tick();
    chk("abort_mem_en", 32'(mem_en), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    ref_rdata = '0;
    #1;
    chk_zero("rst_wait");
    cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    end
    reset = 1'b1;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h104;
    push(1'b1, 1'b0, 32'h104, 32'h0, 0);
    run_one();
    dbg_req = 1'b0;
    tick();

    // misaligned debug write
    dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 32'h102; dbg_wdata = 32'h77;
    push(1'b1, 1'b1, 32'h102, 32'h77, 0);
    run_one();
    dbg_req = 1'b0;
    tick();
    chk("final_mem_addr", mem_addr, 32'h102);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
